// File: rtl/fdiv.sv
// Signed fixed-point divider: restoring division, one quotient bit per cycle,
// fixed latency, round-toward-zero with saturation and divide-by-zero handling.
module fdiv #(
    parameter int DIN_WIDTH  = 16,
    parameter int DIN_FRAC   = 8,
    parameter int DOUT_WIDTH = 16,
    parameter int DOUT_FRAC  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [DIN_WIDTH-1:0]  i_dividend,
    input  logic [DIN_WIDTH-1:0]  i_divisor,
    input  logic                  i_ovr,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic [DOUT_WIDTH-1:0] o_result,
    output logic                  o_ovr
);

    // Both operands share DIN_FRAC, so input scaling cancels in the quotient.
    localparam int QW = DIN_WIDTH + DOUT_FRAC;
    localparam int CW = $clog2(QW + 1);
    // Wide enough to compare the quotient magnitude against both output limits.
    localparam int EW = (QW > DOUT_WIDTH) ? QW + 1 : DOUT_WIDTH + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [DOUT_WIDTH-1:0] MAX_POS = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic [DOUT_WIDTH-1:0] MAX_NEG = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
    localparam logic [EW-1:0] MAX_POS_E = {{(EW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic [EW-1:0] MAX_NEG_E = MAX_POS_E + EW'(1);

    if (DIN_FRAC < 0 || DIN_FRAC >= DIN_WIDTH) begin : g_bad_din_frac
        $error("fdiv: DIN_FRAC must lie in [0, DIN_WIDTH)");
    end

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [QW-1:0]         num_q, num_d;        // dividend bits shifting out, quotient in
    logic [DIN_WIDTH-1:0]  rem_q, rem_d;
    logic [DIN_WIDTH-1:0]  den_q, den_d;
    logic                  neg_q, neg_d;        // result sign
    logic                  dz_q, dz_d;          // divisor was zero
    logic                  dnd_neg_q, dnd_neg_d;
    logic                  ovr_in_q, ovr_in_d;
    logic [DOUT_WIDTH-1:0] result_q, result_d;
    logic                  ovr_q, ovr_d;
    logic                  valid_q, valid_d;

    logic [DIN_WIDTH-1:0]  dividend_mag, divisor_mag;
    logic [DIN_WIDTH:0]    rem_shift;
    logic [DIN_WIDTH-1:0]  rem_diff;
    logic                  take_bit;
    logic [EW-1:0]         q_ext;
    logic [DOUT_WIDTH-1:0] q_lo, q_neg;
    logic [DOUT_WIDTH-1:0] fin_result;
    logic                  fin_sat;

    // Operand magnitudes as unsigned, so the most negative input stays exact.
    always_comb begin
        dividend_mag = i_dividend[DIN_WIDTH-1] ? (~i_dividend + DIN_WIDTH'(1)) : i_dividend;
        divisor_mag  = i_divisor[DIN_WIDTH-1]  ? (~i_divisor + DIN_WIDTH'(1))  : i_divisor;
    end

    // One restoring-division step; the true difference always fits DIN_WIDTH bits
    // whenever it is taken, so the narrow subtract is exact.
    always_comb begin
        rem_shift = {rem_q, num_q[QW-1]};
        take_bit  = (rem_shift >= {1'b0, den_q});
        rem_diff  = rem_shift[DIN_WIDTH-1:0] - den_q;
    end

    // Final sign application, saturation and divide-by-zero selection.
    always_comb begin
        q_ext      = EW'(num_q);
        q_lo       = q_ext[DOUT_WIDTH-1:0];
        q_neg      = ~q_lo + DOUT_WIDTH'(1);
        fin_result = q_lo;
        fin_sat    = 1'b0;
        if (dz_q) begin
            fin_result = dnd_neg_q ? MAX_NEG : MAX_POS;
            fin_sat    = 1'b1;
        end else if (!neg_q) begin
            if (q_ext > MAX_POS_E) begin
                fin_result = MAX_POS;
                fin_sat    = 1'b1;
            end
        end else begin
            fin_result = q_neg;
            if (q_ext > MAX_NEG_E) begin
                fin_result = MAX_NEG;
                fin_sat    = 1'b1;
            end
        end
    end

    // FSM and datapath next-state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        rem_d     = rem_q;
        den_d     = den_q;
        neg_d     = neg_q;
        dz_d      = dz_q;
        dnd_neg_d = dnd_neg_q;
        ovr_in_d  = ovr_in_q;
        result_d  = result_q;
        ovr_d     = ovr_q;
        valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d   = DIV;
                    cnt_d     = CW'(QW);
                    num_d     = QW'(dividend_mag) << DOUT_FRAC;
                    rem_d     = '0;
                    den_d     = divisor_mag;
                    neg_d     = i_dividend[DIN_WIDTH-1] ^ i_divisor[DIN_WIDTH-1];
                    dz_d      = (i_divisor == '0);
                    dnd_neg_d = i_dividend[DIN_WIDTH-1];
                    ovr_in_d  = i_ovr;
                end
            end
            DIV: begin
                num_d = {num_q[QW-2:0], take_bit};
                rem_d = take_bit ? rem_diff : rem_shift[DIN_WIDTH-1:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d  = IDLE;
                valid_d  = 1'b1;
                result_d = fin_result;
                ovr_d    = ovr_in_q | fin_sat;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any running division.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            num_q     <= '0;
            rem_q     <= '0;
            den_q     <= '0;
            neg_q     <= 1'b0;
            dz_q      <= 1'b0;
            dnd_neg_q <= 1'b0;
            ovr_in_q  <= 1'b0;
            result_q  <= '0;
            ovr_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            rem_q     <= rem_d;
            den_q     <= den_d;
            neg_q     <= neg_d;
            dz_q      <= dz_d;
            dnd_neg_q <= dnd_neg_d;
            ovr_in_q  <= ovr_in_d;
            result_q  <= result_d;
            ovr_q     <= ovr_d;
            valid_q   <= valid_d;
        end
    end

    assign o_busy   = (state_q != IDLE);
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_ovr    = ovr_q;

endmodule

// File: doc/fdiv.md
FDIV -- requirements
Module: fdiv

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 16: width of signed input operands.
REQ-002 SHALL have parameter DIN_FRAC, default 8: fractional bits of both input operands.
REQ-003 SHALL have parameter DOUT_WIDTH, default 16: width of signed result.
REQ-004 SHALL have parameter DOUT_FRAC, default 8: fractional bits of result.
REQ-005 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port i_start  input  1  request to start a division; sampled only when o_busy=0.
REQ-008 SHALL have port i_dividend  input  DIN_WIDTH  signed fixed-point dividend.
REQ-009 SHALL have port i_divisor  input  DIN_WIDTH  signed fixed-point divisor.
REQ-010 SHALL have port i_ovr  input  1  upstream overflow flag accompanying the operands.
REQ-011 SHALL have port o_busy  output  1  division in progress; new requests ignored.
REQ-012 SHALL have port o_valid  output  1  one-cycle pulse: o_result/o_ovr updated.
REQ-013 SHALL have port o_result  output  DOUT_WIDTH  signed fixed-point quotient.
REQ-014 SHALL have port o_ovr  output  1  overflow/invalid flag for o_result.

Function
REQ-015 SHALL compute Q = floor(|dividend| * 2^DOUT_FRAC / |divisor|) as an unsigned QW-bit magnitude, QW = DIN_WIDTH + DOUT_FRAC; input scaling cancels, so DIN_FRAC does not affect the arithmetic.
REQ-016 SHALL take operand magnitudes in DIN_WIDTH-bit unsigned form so -2^(DIN_WIDTH-1) is exact.
REQ-017 SHALL use restoring division, one quotient bit per cycle, MSB first; no combinational divide operator.
REQ-018 SHALL have FSM states IDLE, DIV, FIN; IDLE->DIV on i_start=1; DIV->FIN after exactly QW iterations (down-counter reaching 0); FIN->IDLE unconditionally.
REQ-019 SHALL, on IDLE->DIV, latch operand magnitudes, result sign (sign(dividend) XOR sign(divisor)), divisor==0 flag and i_ovr.
REQ-020 SHALL keep o_busy=1 in DIV and FIN, 0 in IDLE; i_start while o_busy=1 SHALL be ignored with no effect on the running operation.
REQ-021 SHALL have fixed latency: i_start sampled at edge k -> o_valid=1 for exactly the cycle after edge k+QW+1; divide-by-zero takes the same latency.
REQ-022 SHALL allow back-to-back operation: i_start in the o_valid cycle is accepted, since o_busy=0 then.
REQ-023 SHALL round toward zero: result = +Q or -Q per latched sign; Q=0 gives 0 regardless of sign.
REQ-024 SHALL saturate: positive Q > 2^(DOUT_WIDTH-1)-1 -> max positive; negative Q > 2^(DOUT_WIDTH-1) -> -2^(DOUT_WIDTH-1); either sets overflow.
REQ-025 SHALL, on divisor==0, output max positive if dividend >= 0, else max negative, with overflow set.
REQ-026 SHALL drive o_ovr = latched i_ovr OR saturation OR divide-by-zero, updated with o_result in FIN.
REQ-027 SHALL hold o_result and o_ovr stable from one o_valid until the next o_valid.

Reset
REQ-028 SHALL, while i_rst_n=0, asynchronously force state IDLE, o_busy=0, o_valid=0, o_result=0, o_ovr=0, and clear counter and working registers.
REQ-029 SHALL abort any in-flight division on reset with no o_valid produced; the first i_start after release starts a fresh operation.

Verification (defaults: QW=24, latency 26 cycles)
REQ-030 SHALL check 0x0300 / 0x0200 (3.0/2.0) -> o_result=0x0180, o_ovr=0, o_valid exactly 26 cycles after start; and -1.0/4.0 (0xFF00/0x0400) -> 0xFFC0.
REQ-031 SHALL check truncation: 0x0100/0x0300 -> 0x0055; 0xFF00/0x0300 -> 0xFFAB; both o_ovr=0.
REQ-032 SHALL check saturation and div-by-zero: 0x7F00/0x0001 -> 0x7FFF with o_ovr=1; 0x8000/0x0000 -> 0x8000 with o_ovr=1; 0x0100/0x0000 -> 0x7FFF with o_ovr=1.
REQ-033 SHALL check i_ovr propagation: 0x0300/0x0200 with i_ovr=1 -> 0x0180, o_ovr=1.
REQ-034 SHALL check handshake: i_start pulsed mid-operation with different operands -> ignored, first result unchanged; i_start in the o_valid cycle -> second result 26 cycles later.
REQ-035 SHALL check reset mid-operation: assert i_rst_n=0 at cycle 10 of a division -> outputs immediately 0, no o_valid; a new 0x0300/0x0200 after release -> 0x0180.
